// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction codes and state-flag bundle shared by the TAP controller.
package jtag_pkg;
  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR,
    S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_t;
  localparam int INSTR_EXTEST = 0;
  localparam int INSTR_SAMPLE_PRELOAD = 1;
  localparam int INSTR_IDCODE = 2;
  localparam int INSTR_BYPASS = -1;
  localparam logic [1:0] IR_CAPTURE = 2'b01;
  typedef struct packed {
    logic tlr;
    logic to_tlr;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;
  } tap_flags_t;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP state machine driven by tms_i, exporting one-hot state flags.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms_i,
  output tap_flags_t flags_o
);
  tap_state_t state_q, state_d;
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) state_q <= S_TLR;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:    state_d = tms_i ? S_TLR    : S_RTI;
      S_RTI:    state_d = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_d = tms_i ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_d = tms_i ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_d = tms_i ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_d = tms_i ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: state_d = tms_i ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: state_d = tms_i ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_d = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_d = tms_i ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_d = tms_i ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_d = tms_i ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_d = tms_i ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: state_d = tms_i ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: state_d = tms_i ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_d = tms_i ? S_SEL_DR : S_RTI;
      default:  state_d = S_TLR;
    endcase
  end
  // to_tlr looks at the next state so the IR reload lands on the edge that enters TLR
  assign flags_o = '{
    tlr:    state_q == S_TLR,
    to_tlr: state_d == S_TLR,
    cap_dr: state_q == S_CAP_DR,
    sh_dr:  state_q == S_SH_DR,
    upd_dr: state_q == S_UPD_DR,
    cap_ir: state_q == S_CAP_IR,
    sh_ir:  state_q == S_SH_IR,
    upd_ir: state_q == S_UPD_IR
  };
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: TAP controller with IR, BYPASS/IDCODE registers and boundary-scan chain controls.
// Define TDO_NEGEDGE_EN to register tdo_o/tdo_en_o on the falling edge of tck.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic tck,
  input  logic trst_n,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_en_o,
  output logic bsr_scan_o,
  input  logic bsr_scan_i,
  output logic bsr_shift_o,
  output logic bsr_capture_o,
  output logic bsr_update_o,
  output logic bsr_mode_o,
  output logic tlr_o
);
  tap_flags_t f;
  logic [IR_W-1:0] ir_q, irs_q;
  logic [31:0] idc_q;
  logic byp_q, sel_bsr, sel_idc, tdo_d, tdo_en_d;
  jtag_tap_fsm u_fsm (.tck(tck), .trst_n(trst_n), .tms_i(tms_i), .flags_o(f));
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      ir_q  <= IR_W'(INSTR_IDCODE);
      irs_q <= IR_W'(IR_CAPTURE);
      idc_q <= IDCODE_VAL;
      byp_q <= 1'b0;
    end else begin
      if (f.to_tlr) ir_q <= IR_W'(INSTR_IDCODE);
      else if (f.upd_ir) ir_q <= irs_q;
      if (f.cap_ir) irs_q <= IR_W'(IR_CAPTURE);
      else if (f.sh_ir) irs_q <= {tdi_i, irs_q[IR_W-1:1]};
      if (f.cap_dr) idc_q <= IDCODE_VAL;
      else if (f.sh_dr) idc_q <= {tdi_i, idc_q[31:1]};
      if (f.cap_dr) byp_q <= 1'b0;
      else if (f.sh_dr) byp_q <= tdi_i;
    end
  // every code other than the three defined ones falls through to the bypass register
  assign sel_bsr = ir_q == IR_W'(INSTR_EXTEST) || ir_q == IR_W'(INSTR_SAMPLE_PRELOAD);
  assign sel_idc = ir_q == IR_W'(INSTR_IDCODE);
  assign tlr_o = f.tlr;
  assign bsr_scan_o = tdi_i;
  assign bsr_shift_o = f.sh_dr & sel_bsr;
  assign bsr_capture_o = (f.cap_dr | f.sh_dr) & sel_bsr;
  assign bsr_update_o = f.upd_dr & sel_bsr;
  assign bsr_mode_o = ir_q == IR_W'(INSTR_EXTEST);
  assign tdo_en_d = f.sh_ir | f.sh_dr;
  assign tdo_d = f.sh_ir ? irs_q[0] : !f.sh_dr ? 1'b0 : sel_bsr ? bsr_scan_i : sel_idc ? idc_q[0] : byp_q;
`ifdef TDO_NEGEDGE_EN
  logic tdo_q, tdo_en_q;
  always_ff @(negedge tck or negedge trst_n)
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  assign tdo_o = tdo_q;
  assign tdo_en_o = tdo_en_q;
`else
  assign tdo_o = tdo_d;
  assign tdo_en_o = tdo_en_d;
`endif
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed bench for jtag_tap_ctrl with a queue-based reference model checked every cycle.
module tb_jtag_tap_ctrl;
  logic tck = 1'b0, trst_n = 1'b1, tms_i = 1'b1, tdi_i = 1'b0, bsr_scan_i = 1'b0;
  logic tdo_o, tdo_en_o, bsr_scan_o, bsr_shift_o, bsr_capture_o, bsr_update_o, bsr_mode_o, tlr_o;
  int n_cmp = 0, n_bad = 0;
  bit bsr_any = 1'b0;
  logic [31:0] o;
  logic [31:0] idv = 32'h1000_0001;

  always #5 tck = ~tck;

  jtag_tap_ctrl dut (
    .tck(tck), .trst_n(trst_n), .tms_i(tms_i), .tdi_i(tdi_i), .tdo_o(tdo_o), .tdo_en_o(tdo_en_o),
    .bsr_scan_o(bsr_scan_o), .bsr_scan_i(bsr_scan_i), .bsr_shift_o(bsr_shift_o),
    .bsr_capture_o(bsr_capture_o), .bsr_update_o(bsr_update_o), .bsr_mode_o(bsr_mode_o), .tlr_o(tlr_o)
  );

  typedef enum {RESET, IDLE, DR_SEL, DR_CAP, DR_SHIFT, DR_EXIT1, DR_PAUSE, DR_EXIT2, DR_UPD,
                IR_SEL, IR_CAP, IR_SHIFT, IR_EXIT1, IR_PAUSE, IR_EXIT2, IR_UPD} ms_e;
  ms_e m_st = RESET, m_nx;
  int m_ir = 2;
  bit irq[$];
  bit drq[$];

  function automatic ms_e nxt(ms_e s, bit t);
    case (s)
      RESET:              return t ? RESET : IDLE;
      IDLE:               return t ? DR_SEL : IDLE;
      DR_SEL:             return t ? IR_SEL : DR_CAP;
      DR_CAP, DR_SHIFT:   return t ? DR_EXIT1 : DR_SHIFT;
      DR_EXIT1:           return t ? DR_UPD : DR_PAUSE;
      DR_PAUSE:           return t ? DR_EXIT2 : DR_PAUSE;
      DR_EXIT2:           return t ? DR_UPD : DR_SHIFT;
      IR_SEL:             return t ? RESET : IR_CAP;
      IR_CAP, IR_SHIFT:   return t ? IR_EXIT1 : IR_SHIFT;
      IR_EXIT1:           return t ? IR_UPD : IR_PAUSE;
      IR_PAUSE:           return t ? IR_EXIT2 : IR_PAUSE;
      IR_EXIT2:           return t ? IR_UPD : IR_SHIFT;
      default:            return t ? DR_SEL : IDLE;
    endcase
  endfunction

  function automatic int irq_val();
    int v = 0;
    foreach (irq[i]) v |= int'(irq[i]) << i;
    return v;
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      m_st = RESET;
      m_ir = 2;
      irq.delete();
      drq.delete();
    end else begin
      m_nx = nxt(m_st, tms_i);
      case (m_st)
        IR_CAP: begin
          irq.delete();
          irq.push_back(1'b1);
          for (int i = 1; i < 4; i++) irq.push_back(1'b0);
        end
        IR_SHIFT: begin
          void'(irq.pop_front());
          irq.push_back(tdi_i);
        end
        IR_UPD: m_ir = irq_val();
        DR_CAP: begin
          drq.delete();
          if (m_ir == 2) for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
          else if (m_ir > 2) drq.push_back(1'b0);
        end
        DR_SHIFT: if (drq.size() > 0) begin
          void'(drq.pop_front());
          drq.push_back(tdi_i);
        end
        default: ;
      endcase
      if (m_nx == RESET) m_ir = 2;
      m_st = m_nx;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic compare_all();
    bit bsr, shdr, shir, etdo;
    bsr  = (m_ir == 0) || (m_ir == 1);
    shdr = m_st == DR_SHIFT;
    shir = m_st == IR_SHIFT;
    etdo = shir ? (irq.size() > 0 ? irq[0] : 1'b0) :
           shdr ? (bsr ? bsr_scan_i : (drq.size() > 0 ? drq[0] : 1'b0)) : 1'b0;
    chk("m_tlr", 32'(tlr_o), 32'(m_st == RESET));
    chk("m_tdo_en", 32'(tdo_en_o), 32'(shir | shdr));
    chk("m_tdo", 32'(tdo_o), 32'(etdo));
    chk("m_shift", 32'(bsr_shift_o), 32'(shdr && bsr));
    chk("m_capture", 32'(bsr_capture_o), 32'((shdr || m_st == DR_CAP) && bsr));
    chk("m_update", 32'(bsr_update_o), 32'(m_st == DR_UPD && bsr));
    chk("m_mode", 32'(bsr_mode_o), 32'(m_ir == 0));
    chk("m_scan", 32'(bsr_scan_o), 32'(tdi_i));
  endtask

  always @(negedge tck) begin
    #1;
    compare_all();
    if (bsr_shift_o | bsr_capture_o | bsr_update_o | bsr_mode_o) bsr_any = 1'b1;
  end

  task automatic tick(input bit t, input bit d);
    tms_i = t;
    tdi_i = d;
    @(posedge tck);
    #1;
  endtask

  task automatic shift_n(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      bsr_scan_i = ~din[i];
      @(negedge tck);
      #2;
      dout[i] = tdo_o;
      tick(i == n - 1, din[i]);
    end
  endtask

  task automatic load_ir(input logic [31:0] v, output logic [31:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_n(4, v, cap);
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    tick(1, 0); tick(0, 0); tick(0, 0);
    shift_n(n, din, dout);
    tick(1, 0);
    tick(0, 0);
  endtask

  initial begin
    #1 trst_n = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    chk("rst_tlr", 32'(tlr_o), 32'd1);
    chk("rst_mode", 32'(bsr_mode_o), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en_o), 32'd0);
    #2 trst_n = 1'b1;
    tick(0, 0);
    dr_scan(32, 32'h0, o);
    chk("idcode", o, 32'h1000_0001);
    load_ir(32'hF, o);
    chk("ir_capture", {28'd0, o[3:0]}, 32'h1);
    dr_scan(4, 32'b1101, o);
    chk("bypass", {28'd0, o[3:0]}, 32'hA);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_n(4, 32'h0, o);
    tick(1, 0);
    chk("mode_in_upd_ir", 32'(bsr_mode_o), 32'd0);
    tick(0, 0);
    chk("mode_after_upd", 32'(bsr_mode_o), 32'd1);
    tick(1, 0);
    tick(0, 0);
    chk("cap_dr_capture", 32'(bsr_capture_o), 32'd1);
    chk("cap_dr_shift", 32'(bsr_shift_o), 32'd0);
    tick(0, 0);
    chk("sh_dr_capture", 32'(bsr_capture_o), 32'd1);
    chk("sh_dr_shift", 32'(bsr_shift_o), 32'd1);
    shift_n(3, 32'b101, o);
    chk("bsr_tdo", {29'd0, o[2:0]}, 32'b010);
    tick(1, 0);
    chk("upd_dr_update", 32'(bsr_update_o), 32'd1);
    tick(0, 0);
    chk("rti_update", 32'(bsr_update_o), 32'd0);
    load_ir(32'h7, o);
    bsr_any = 1'b0;
    dr_scan(4, 32'b0110, o);
    chk("undef_bypass", {28'd0, o[3:0]}, 32'hC);
    chk("undef_bsr_quiet", 32'(bsr_any), 32'd0);
    load_ir(32'h0, o);
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("pre_rst_mode", 32'(bsr_mode_o), 32'd1);
    #2 trst_n = 1'b0;
    #1;
    chk("arst_tlr", 32'(tlr_o), 32'd1);
    chk("arst_mode", 32'(bsr_mode_o), 32'd0);
    chk("arst_shift", 32'(bsr_shift_o), 32'd0);
    chk("arst_capture", 32'(bsr_capture_o), 32'd0);
    chk("arst_update", 32'(bsr_update_o), 32'd0);
    chk("arst_tdo_en", 32'(tdo_en_o), 32'd0);
    chk("arst_tdo", 32'(tdo_o), 32'd0);
    @(posedge tck);
    #3 trst_n = 1'b1;
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    chk("pause_ir_tlr", 32'(tlr_o), 32'd0);
    repeat (5) tick(1, 0);
    chk("five_ones_tlr", 32'(tlr_o), 32'd1);
    tick(0, 0);
    load_ir(32'h0, o);
    chk("extest_again", 32'(bsr_mode_o), 32'd1);
    repeat (5) tick(1, 0);
    chk("tlr_reload_tlr", 32'(tlr_o), 32'd1);
    chk("tlr_reload_mode", 32'(bsr_mode_o), 32'd0);
    @(negedge tck);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller that sits directly upstream of the boundary scan chain (cells of type bsc).
- Runs the 16-state TAP FSM from tms_i.
- Holds the instruction register plus the BYPASS and IDCODE data registers.
- Decodes the active instruction into the chain's shift/capture/update/mode controls.
- Muxes the selected register onto tdo_o.

Parameters:
IR_W, 4, instruction register width (min 2)
IDCODE_VAL, 32'h1000_0001, IDCODE register contents; bit0 must be 1

Ports:
tck  input  1  test clock; all state on posedge
trst_n  input  1  asynchronous active-low reset
tms_i  input  1  test mode select
tdi_i  input  1  test data in
tdo_o  output  1  test data out
tdo_en_o  output  1  high in Shift-IR or Shift-DR
bsr_scan_o  output  1  serial in to chain (= tdi_i)
bsr_scan_i  input  1  serial out of last chain cell
bsr_shift_o  output  1  chain shift_i
bsr_capture_o  output  1  chain capture_i (register enable)
bsr_update_o  output  1  chain update_i
bsr_mode_o  output  1  chain mode_i
tlr_o  output  1  high while in Test-Logic-Reset

Behaviour:
- Reset: trst_n low asynchronously forces:
  - state = TEST_LOGIC_RESET, IR = INSTR_IDCODE, bypass = 0, idcode shift reg = IDCODE_VAL.
  - Outputs: tlr_o=1, all bsr_* = 0, tdo_en_o = 0, tdo_o = 0.
- FSM: standard 16 states. Transitions on posedge tck per tms_i, as in 1149.1:
  - TLR -(0)-> RTI; RTI -(1)-> SEL_DR; SEL_DR -(1)-> SEL_IR -(1)-> TLR.
  - CAPTURE -(0)-> SHIFT, (1)-> EXIT1; SHIFT -(1)-> EXIT1; EXIT1 -(0)-> PAUSE, (1)-> UPDATE.
  - PAUSE -(1)-> EXIT2; EXIT2 -(0)-> SHIFT, (1)-> UPDATE; UPDATE -(0)-> RTI, (1)-> SEL_DR.
  - Five consecutive tms_i=1 reach TLR from any state.
  - Entering TLR synchronously reloads IR = INSTR_IDCODE.
- Instruction register:
  - Capture-IR: shift stage loads {0.., 2'b01}.
  - Shift-IR: shift right, tdi_i into MSB, LSB to tdo.
  - Update-IR: active IR <= shift stage on posedge while in Update-IR; new IR is visible the next cycle.
- Decode (constants in package):
  - EXTEST = 0, SAMPLE_PRELOAD = 1, IDCODE = 2, BYPASS = all-ones.
  - Any undefined code behaves as BYPASS.
- DR select: EXTEST or SAMPLE_PRELOAD selects the BSR; IDCODE selects the 32-bit idcode register; otherwise the 1-bit bypass register.
- Bypass register: Capture-DR loads 0; Shift-DR loads tdi_i.
- Idcode register: Capture-DR loads IDCODE_VAL; Shift-DR shifts right with tdi_i into MSB.
- Chain controls (combinational from state and active IR; gated by BSR selected):
  - bsr_shift_o = Shift-DR.
  - bsr_capture_o = Capture-DR | Shift-DR. The chain uses capture as its FF enable, so it must also be high while shifting.
  - bsr_update_o = Update-DR. Exactly one cycle per pass through Update-DR.
  - bsr_mode_o = (IR == EXTEST), independent of state. Deasserts immediately when IR leaves EXTEST and on reset.
- TDO source:
  - Shift-IR: IR shift-stage bit0.
  - Shift-DR: selected DR bit0 (bsr_scan_i for the BSR).
  - Otherwise 0.
- trst_n asserted mid-shift: shift contents are discarded and mode drops in the same cycle.

Optional Feature:
TDO_NEGEDGE_EN
- Defined: tdo_o and tdo_en_o are registered on negedge tck from the combinational TDO source; both reset to 0 by trst_n. This gives a half-cycle later output, compliant with 1149.1.
- Undefined: tdo_o and tdo_en_o are purely combinational, valid at posedge, with zero added latency.

Decomposition:
- Package jtag_pkg holds:
  - tap_state_t (16-state encoding, 4 bits).
  - INSTR_EXTEST, INSTR_SAMPLE_PRELOAD, INSTR_IDCODE, INSTR_BYPASS.
  - IR capture pattern.
- Sub-module jtag_tap_fsm: state register and next-state logic only, exporting one-hot state decode flags.
- IR, DR and TDO logic stay in jtag_tap_ctrl.

Test Plan:
- Reset and idle: pulse trst_n low mid-Shift-DR → immediately tlr_o=1, bsr_mode_o=0, all bsr_* = 0. Then tms_i=1 ×5 from Pause-IR → state TLR.
- IDCODE readout after reset: tms 0,1,0,0 then 32 Shift-DR cycles with tdi=0 → tdo_o LSB-first = 32'h1000_0001 (first bit 1).
- IR capture: enter Shift-IR, shift 4 bits → tdo_o = 1,0,0,0. Load 4'hF → BYPASS; shift 1,0,1,1 on tdi → tdo_o = 0,1,0,1 (one-cycle delay).
- EXTEST: load IR=0 → bsr_mode_o rises the cycle after Update-IR. Then a DR scan: Capture-DR gives capture=1, shift=0; Shift-DR gives capture=1, shift=1; Update-DR gives a single-cycle bsr_update_o.
- Undefined IR (4'h7) → bypass behaviour; bsr_* stay 0 through a full DR scan.
- With TDO_NEGEDGE_EN: tdo_o changes only on tck falling edges and lags the combinational source by half a cycle.
